parity_checker_rx: RTL
======================

PARITY_CHECKER_RX -- requirements
Module: parity_checker_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 3, meaning the number of data bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 Port clk SHALL be input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid SHALL be input, 1 bit: in_bit (and in_sof) are sampled this cycle.
REQ-006 Port in_bit SHALL be input, 1 bit: the serial frame bit.
REQ-007 Port in_sof SHALL be input, 1 bit: qualified by in_valid, marks the first data bit of a frame.
REQ-008 Port out_valid SHALL be output, 1 bit: a one-cycle pulse meaning a frame is complete.
REQ-009 Port out_data SHALL be output, DATA_W bits: the received data bits.
REQ-010 Port out_err SHALL be output, 1 bit: a parity mismatch for the frame in out_data.
REQ-011 Port busy SHALL be output, 1 bit: high while a frame is partially received.

Function
REQ-012 A frame SHALL be DATA_W data bits followed by 1 parity bit, each accepted only in a cycle where in_valid=1.
REQ-013 The first data bit SHALL be the MSB; out_data[DATA_W-1] is the first bit received.
REQ-014 The FSM SHALL have states IDLE, DATA and PARITY.
REQ-015 In IDLE, in_valid=1 with in_sof=1 SHALL store the bit, set the bit counter to 1 and go to DATA (or to PARITY if DATA_W=1); beats without in_sof SHALL be ignored.
REQ-016 In DATA, each valid beat SHALL shift in one bit; after bit DATA_W is accepted the FSM SHALL go to PARITY.
REQ-017 In PARITY, a valid beat SHALL be taken as the parity bit and the FSM SHALL return to IDLE.
REQ-018 Cycles with in_valid=0 SHALL hold all state; there is no timeout.
REQ-019 out_valid SHALL pulse for exactly one cycle on the cycle after the parity bit is accepted (latency 1).
REQ-020 out_data and out_err SHALL be registered and SHALL hold their values until the next completed frame.
REQ-021 out_err SHALL be XOR(data bits) XOR parity_bit XOR ODD_PARITY, so that 1 means error.
REQ-022 in_sof=1 on a valid beat while in DATA or PARITY SHALL abort the partial frame without output and start a new frame with that bit as the first data bit.
REQ-023 A completed frame SHALL NOT raise busy; a new frame MAY start (in_sof) in the same cycle out_valid is high.
REQ-024 busy SHALL be 1 exactly when the state is DATA or PARITY.

Reset
REQ-025 rst=1 SHALL asynchronously force: state IDLE, bit counter 0, shift register 0, out_valid 0, out_data 0, out_err 0 and busy 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, only an in_sof beat starts reception.
REQ-027 Reset SHALL clear the error counter when PARITY_ERR_CNT_EN is defined.

Configuration
REQ-028 With macro PARITY_ERR_CNT_EN defined, the block SHALL add output err_cnt (8 bits), incremented on each out_valid with out_err=1 and saturating at 255.
REQ-029 With PARITY_ERR_CNT_EN undefined, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Default parameters, frame bits 1,0,1 then parity 0 with in_sof on the first bit -> out_valid pulses once, out_data=3'b101, out_err=0.
REQ-031 Frame 1,0,1 with parity 1 -> out_data=3'b101, out_err=1; all 8 data values with generated even parity -> out_err=0 each.
REQ-032 Frame 1,1,0 with in_valid low for 3 cycles between bits 2 and 3, parity 0 -> out_data=3'b110, out_err=0, busy high throughout the gap.
REQ-033 Bits 1,1 then in_sof with frame 0,0,1 and parity 1 -> a single out_valid, out_data=3'b001, out_err=0.
REQ-034 rst pulsed after 2 data bits, then a full frame 0,1,1 with parity 0 -> out_valid only for the new frame, out_data=3'b011.
REQ-035 With PARITY_ERR_CNT_EN defined, 300 bad-parity frames -> err_cnt=255; rst -> err_cnt=0.

Source files
------------

// File: rtl/parity_checker_rx.sv
// Serial frame receiver: MSB-first data bits plus a parity bit, registered result with error flag.
// Optional saturating parity-error counter on err_cnt when PARITY_ERR_CNT_EN is defined.
module parity_checker_rx #(
    parameter int DATA_W     = 3,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
`ifdef PARITY_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              busy
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_nextCnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_nextShift;
    logic                r_outValid;
    logic [DATA_W-1:0]   r_outData;
    logic                r_outErr;
    logic                w_frameDone;
    logic                w_parityErr;

    // A valid in_sof beat always restarts reception, whatever the current state,
    // so a partial frame is dropped silently and the beat becomes the new MSB.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextShift = r_shift;
        w_frameDone = 1'b0;
        w_parityErr = (^r_shift) ^ in_bit ^ ODD_BIT;
        if (in_valid && in_sof) begin
            w_nextShift = DATA_W'(in_bit);
            w_nextCnt   = CNT_W'(1);
            w_nextState = (DATA_W == 1) ? PARITY : DATA;
        end else if (in_valid) begin
            case (r_state)
                DATA: begin
                    w_nextShift = (r_shift << 1) | DATA_W'(in_bit);
                    w_nextCnt   = r_cnt + CNT_W'(1);
                    if (w_nextCnt == CNT_W'(DATA_W)) begin
                        w_nextState = PARITY;
                    end
                end
                PARITY: begin
                    w_frameDone = 1'b1;
                    w_nextCnt   = '0;
                    w_nextState = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // The result registers only load on a completed frame, so they hold across idle time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outErr   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_shift    <= w_nextShift;
            r_outValid <= w_frameDone;
            if (w_frameDone) begin
                r_outData <= r_shift;
                r_outErr  <= w_parityErr;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] r_errCnt;

    // Counts in step with the out_valid pulse and sticks at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCnt <= '0;
        end else if (w_frameDone && w_parityErr && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt = r_errCnt;
`endif

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign busy      = (r_state != IDLE);

endmodule
